// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data accesses beat instruction fetches.
// Define ARB_FAIRNESS_EN to bound fetch starvation at STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IREAD  = 2'b01,
        DREAD  = 2'b10,
        DWRITE = 2'b11
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'b10;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ramaddr_q, ramaddr_d;
    logic [DATA_W-1:0] ramstore_q, ramstore_d;

    logic fair_force;
    logic grant_w, grant_r, grant_i;
    logic access;

    assign access = (ramstate == RAM_ACCESS);

    always_comb begin
        grant_w = 1'b0;
        grant_r = 1'b0;
        grant_i = 1'b0;
        if (state_q == IDLE) begin
            grant_i = fair_force || (iREN && !dWEN && !dREN);
            grant_w = dWEN && !fair_force;
            grant_r = dREN && !dWEN && !fair_force;
        end
    end

`ifdef ARB_FAIRNESS_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q, starve_d;

    assign fair_force = iREN && (starve_q >= LIMIT);

    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (grant_i || !iREN) begin
                starve_d = '0;
            end else if ((grant_w || grant_r) && starve_q < LIMIT) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign fair_force = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ramaddr_d  = ramaddr_q;
        ramstore_d = ramstore_q;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d   = IREAD;
                    ramaddr_d = iaddr;
                end else if (grant_w) begin
                    state_d    = DWRITE;
                    ramaddr_d  = daddr;
                    ramstore_d = dstore;
                end else if (grant_r) begin
                    state_d   = DREAD;
                    ramaddr_d = daddr;
                end
            end
            IREAD: begin
                ramREN = 1'b1;
                if (access) begin
                    state_d = IDLE;
                    // A withdrawn request still lets the RAM finish, but sees nothing.
                    if (iREN) begin
                        iwait = 1'b0;
                        iload = ramload;
                    end
                end
            end
            DREAD: begin
                ramREN = 1'b1;
                if (access) begin
                    state_d = IDLE;
                    if (dREN) begin
                        dwait = 1'b0;
                        dload = ramload;
                    end
                end
            end
            DWRITE: begin
                ramWEN = 1'b1;
                if (access) begin
                    state_d = IDLE;
                    dwait   = !dWEN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
        end else begin
            state_q    <= state_d;
            ramaddr_q  <= ramaddr_d;
            ramstore_q <= ramstore_d;
        end
    end

    assign ramaddr  = ramaddr_q;
    assign ramstore = ramstore_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a latency-programmable RAM model.
// Fetch-fairness expectations follow ARB_FAIRNESS_EN.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int n_chk = 0;
    int n_fail = 0;

    mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(4)
    ) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    // RAM model: ERROR for err_n strobe cycles, BUSY for busy_n, then ACCESS.
    int err_n = 0;
    int busy_n = 0;
    int rcnt = 0;
    logic [31:0]   ram [1024];
    logic [1023:0] ram_v = '0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        if (a == 32'h40) return 32'h8C010004;
        return 32'h5A000000 ^ a;
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (ram_v[a[11:2]]) return ram[a[11:2]];
        return dflt(a);
    endfunction

    assign ramload  = ram_v[ramaddr[11:2]] ? ram[ramaddr[11:2]] : dflt(ramaddr);
    assign ramstate = !(ramREN || ramWEN) ? 2'b00 :
                      (rcnt < err_n) ? 2'b11 :
                      (rcnt < err_n + busy_n) ? 2'b01 : 2'b10;

    always @(posedge CLK) begin
        rcnt <= (ramREN || ramWEN) ? rcnt + 1 : 0;
        if (ramWEN && ramstate == 2'b10) begin
            ram[ramaddr[11:2]]   <= ramstore;
            ram_v[ramaddr[11:2]] <= 1'b1;
        end
    end

    typedef struct {
        logic        isd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int done_cnt = 0;
    int ren_cyc = 0;
    int wen_cyc = 0;
    int ilow = 0;
    int dlow = 0;

    always @(negedge CLK) begin
        if (nRST) begin
            if (ramREN) ren_cyc++;
            if (ramWEN) wen_cyc++;
            if (!iwait) ilow++;
            if (!dwait) dlow++;
            if (!iwait || !dwait) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_empty: iwait=%b dwait=%b, none expected",
                             iwait, dwait);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ((!dwait) !== mon_e.isd || (!iwait) !== !mon_e.isd) begin
                        n_fail++;
                        $display("FAIL sb_owner: iwait=%b dwait=%b, want data=%b",
                                 iwait, dwait, mon_e.isd);
                    end else if (mon_e.wr) begin
                        if (ramWEN !== 1'b1 || ramREN !== 1'b0 ||
                            ramaddr !== mon_e.addr || ramstore !== mon_e.data) begin
                            n_fail++;
                            $display("FAIL sb_write: wen=%b ren=%b %h/%h, want %h/%h",
                                     ramWEN, ramREN, ramaddr, ramstore,
                                     mon_e.addr, mon_e.data);
                        end
                    end else begin
                        if ((mon_e.isd ? dload : iload) !== mon_e.data ||
                            ramaddr !== mon_e.addr || ramREN !== 1'b1) begin
                            n_fail++;
                            $display("FAIL sb_read: load=%h addr=%h ren=%b, want %h @%h",
                                     mon_e.isd ? dload : iload, ramaddr, ramREN,
                                     mon_e.data, mon_e.addr);
                        end
                    end
                end
                done_cnt++;
            end
            n_chk++;
            if ((iwait && iload !== '0) || (dwait && dload !== '0)) begin
                n_fail++;
                $display("FAIL idle_load: iload=%h dload=%h, want 0 while waiting",
                         iload, dload);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (done_cnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push(input logic isd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.isd = isd; e.wr = wr; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        n_chk++;
        if (iwait !== 1'b1 || dwait !== 1'b1 || ramREN !== 1'b0 || ramWEN !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: iw=%b dw=%b ren=%b wen=%b, want 1 1 0 0",
                     iwait, dwait, ramREN, ramWEN);
        end
        n_chk++;
        if (ramaddr !== '0 || ramstore !== '0 || iload !== '0 || dload !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h store=%h il=%h dl=%h, want 0",
                     ramaddr, ramstore, iload, dload);
        end
        #1 nRST = 1'b1;
        tick();
    endtask

    task automatic test_ifetch();
        int r0, il0, tgt;
        bit ok;
        err_n = 0; busy_n = 2;
        r0 = ren_cyc; il0 = ilow; tgt = done_cnt + 1;
        push(1'b0, 1'b0, 32'h40, 32'h8C010004);
        iaddr = 32'h40; iREN = 1'b1;
        @(negedge CLK);
        n_chk++;
        if (ramREN !== 1'b0) begin
            n_fail++;
            $display("FAIL ifetch_lat: ramREN=%b in request cycle, want 0", ramREN);
        end
        wait_done(tgt, 20, ok);
        iREN = 1'b0;
        tick();
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ifetch_timeout: done=%0d, want %0d", done_cnt, tgt);
        end
        n_chk++;
        if (ren_cyc - r0 != 3 || ilow - il0 != 1) begin
            n_fail++;
            $display("FAIL ifetch_shape: ren=%0d ilow=%0d, want 3 and 1",
                     ren_cyc - r0, ilow - il0);
        end
    endtask

    task automatic test_priority();
        int tgt;
        bit ok;
        err_n = 0; busy_n = 1;
        tgt = done_cnt + 1;
        push(1'b1, 1'b0, 32'h100, model_rd(32'h100));
        push(1'b0, 1'b0, 32'h44, model_rd(32'h44));
        iaddr = 32'h44; iREN = 1'b1;
        daddr = 32'h100; dREN = 1'b1;
        wait_done(tgt, 20, ok);
        dREN = 1'b0;
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL prio_d_timeout: done=%0d, want %0d", done_cnt, tgt);
        end
        @(negedge CLK);
        n_chk++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_gap: ren=%b wen=%b, want idle cycle", ramREN, ramWEN);
        end
        @(negedge CLK);
        n_chk++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin
            n_fail++;
            $display("FAIL prio_ifetch: ren=%b addr=%h, want 1 @00000044",
                     ramREN, ramaddr);
        end
        wait_done(tgt + 1, 20, ok);
        iREN = 1'b0;
        tick();
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL prio_i_timeout: done=%0d, want %0d", done_cnt, tgt + 1);
        end
    endtask

    task automatic test_write();
        int r0, w0, tgt;
        bit ok;
        err_n = 0; busy_n = 1;
        r0 = ren_cyc; w0 = wen_cyc; tgt = done_cnt + 1;
        push(1'b1, 1'b1, 32'h200, 32'hDEADBEEF);
        daddr = 32'h200; dstore = 32'hDEADBEEF; dWEN = 1'b1;
        wait_done(tgt, 20, ok);
        dWEN = 1'b0;
        tick();
        n_chk++;
        if (!ok || ren_cyc != r0 || wen_cyc - w0 != 2) begin
            n_fail++;
            $display("FAIL write_shape: ok=%b ren=%0d wen=%0d, want 1 0 2",
                     ok, ren_cyc - r0, wen_cyc - w0);
        end
        push(1'b1, 1'b0, 32'h200, 32'hDEADBEEF);
        dREN = 1'b1;
        wait_done(tgt + 1, 20, ok);
        dREN = 1'b0;
        tick();
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL readback_timeout: done=%0d, want %0d", done_cnt, tgt + 1);
        end
    endtask

    task automatic test_error();
        int r0, d0, tgt, errs, bad;
        bit ok;
        err_n = 3; busy_n = 0;
        r0 = ren_cyc; d0 = dlow; tgt = done_cnt + 1;
        errs = 0; bad = 0; ok = 1'b0;
        push(1'b1, 1'b0, 32'h104, model_rd(32'h104));
        daddr = 32'h104; dREN = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge CLK);
            if (ramstate == 2'b11) begin
                errs++;
                if (dwait !== 1'b1 || ramREN !== 1'b1) bad++;
            end
            tick();
            if (done_cnt >= tgt) begin
                ok = 1'b1;
                break;
            end
        end
        dREN = 1'b0;
        tick();
        err_n = 0;
        n_chk++;
        if (!ok || errs != 3 || bad != 0) begin
            n_fail++;
            $display("FAIL error_hold: ok=%b errs=%0d bad=%0d, want 1 3 0",
                     ok, errs, bad);
        end
        n_chk++;
        if (ren_cyc - r0 != 4 || dlow - d0 != 1) begin
            n_fail++;
            $display("FAIL error_shape: ren=%0d dlow=%0d, want 4 and 1",
                     ren_cyc - r0, dlow - d0);
        end
    endtask

    task automatic test_reset_mid();
        int tgt;
        bit ok;
        err_n = 0; busy_n = 5;
        daddr = 32'h300; dstore = 32'h12345678; dWEN = 1'b1;
        tick();
        @(negedge CLK);
        n_chk++;
        if (ramWEN !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: ramWEN=%b, want 1", ramWEN);
        end
        nRST = 1'b0;
        #1;
        n_chk++;
        if (ramWEN !== 1'b0 || dwait !== 1'b1 || ramaddr !== '0 || ramstore !== '0) begin
            n_fail++;
            $display("FAIL rstmid: wen=%b dw=%b addr=%h store=%h, want 0 1 0 0",
                     ramWEN, dwait, ramaddr, ramstore);
        end
        dWEN = 1'b0;
        #2 nRST = 1'b1;
        tick();
        busy_n = 1;
        tgt = done_cnt + 1;
        push(1'b0, 1'b0, 32'h48, model_rd(32'h48));
        iaddr = 32'h48; iREN = 1'b1;
        wait_done(tgt, 20, ok);
        iREN = 1'b0;
        tick();
        n_chk++;
        if (!ok || ram_v[32'h300 >> 2] !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_post: ok=%b written=%b, want 1 0",
                     ok, ram_v[32'h300 >> 2]);
        end
    endtask

    task automatic test_fairness();
        int i0, d0, tgt, want_i;
        bit ok;
        logic isd;
        err_n = 0; busy_n = 0;
        i0 = ilow; d0 = dlow; tgt = done_cnt + 10; want_i = 0;
        for (int t = 0; t < 10; t++) begin
`ifdef ARB_FAIRNESS_EN
            isd = (t % 5 != 4);
`else
            isd = 1'b1;
`endif
            if (!isd) want_i++;
            push(isd, 1'b0, isd ? 32'h108 : 32'h4C,
                 isd ? model_rd(32'h108) : model_rd(32'h4C));
        end
        iaddr = 32'h4C; iREN = 1'b1;
        daddr = 32'h108; dREN = 1'b1;
        wait_done(tgt, 60, ok);
        iREN = 1'b0; dREN = 1'b0;
        tick();
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fair_timeout: done=%0d, want %0d", done_cnt, tgt);
        end
        n_chk++;
        if (ilow - i0 != want_i || dlow - d0 != 10 - want_i) begin
            n_fail++;
            $display("FAIL fair_mix: i=%0d d=%0d, want %0d and %0d",
                     ilow - i0, dlow - d0, want_i, 10 - want_i);
        end
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_priority();
        test_write();
        test_error();
        test_reset_mid();
        test_fairness();
        repeat (3) tick();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d pending, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
